// File: rtl/hpdcache_cmo_arb.sv
// Round-robin arbiter/sequencer of CMO requesters onto the single HPDcache CMO handler.
// Op bits: [0] fence, [1] inval_by_nline, [2] inval_all, [3] inval_by_set. Stats: `HPDCACHE_CMO_ARB_STATS_EN.
`timescale 1ns/1ps
module hpdcache_cmo_arb #(
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned STATS_W = 16,
  parameter int unsigned ADDR_W  = 40,
  parameter int unsigned DATA_W  = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [N_REQ*4-1:0]      req_op_i,
  input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [N_REQ*DATA_W-1:0] req_wdata_i,
  output logic [N_REQ-1:0]        rsp_valid_o,
  output logic                    rsp_error_o,
  output logic                    cmo_req_valid_o,
  input  logic                    cmo_req_ready_i,
  output logic [3:0]              cmo_req_op_o,
  output logic [ADDR_W-1:0]       cmo_req_addr_o,
  output logic [DATA_W-1:0]       cmo_req_wdata_o,
`ifdef HPDCACHE_CMO_ARB_STATS_EN
  output logic [STATS_W-1:0]      stat_fence_o,
  output logic [STATS_W-1:0]      stat_inval_o,
  output logic [STATS_W-1:0]      stat_err_o,
`endif
  output logic                    busy_o
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, gnt_idx, next_ptr;
  logic [N_REQ-1:0]    gnt_oh, gnt_oh_q;
  logic                gnt_found, accept, sel_legal, err_q;
  logic [3:0]          sel_op, op_q;
  logic [ADDR_W-1:0]   sel_addr, addr_q;
  logic [DATA_W-1:0]   sel_wdata, wdata_q;

  // Two passes: first valid at or above the pointer, else first valid below it.
  always_comb begin
    gnt_oh    = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (!gnt_found && req_valid_i[j] && (32'(rr_ptr_q) <= j)) begin
        gnt_oh[j] = 1'b1;
        gnt_idx   = PTR_W'(j);
        gnt_found = 1'b1;
      end
    end
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (!gnt_found && req_valid_i[j]) begin
        gnt_oh[j] = 1'b1;
        gnt_idx   = PTR_W'(j);
        gnt_found = 1'b1;
      end
    end
  end

  assign next_ptr = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
  assign accept   = (state_q == S_IDLE) && gnt_found;

  always_comb begin
    sel_op    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      sel_op    = sel_op    | (req_op_i[i*4 +: 4]              & {4{gnt_oh[i]}});
      sel_addr  = sel_addr  | (req_addr_i[i*ADDR_W +: ADDR_W]  & {ADDR_W{gnt_oh[i]}});
      sel_wdata = sel_wdata | (req_wdata_i[i*DATA_W +: DATA_W] & {DATA_W{gnt_oh[i]}});
    end
  end

  assign sel_legal = (sel_op != 4'b0000) && ((sel_op & (sel_op - 4'd1)) == 4'b0000);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (gnt_found) state_d = sel_legal ? S_ISSUE : S_RESP;
      S_ISSUE: if (cmo_req_ready_i) state_d = S_WAIT;
      S_WAIT:  if (cmo_req_ready_i) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      gnt_oh_q <= '0;
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        rr_ptr_q <= next_ptr;
        gnt_oh_q <= gnt_oh;
        op_q     <= sel_op;
        addr_q   <= sel_addr;
        wdata_q  <= sel_wdata;
        err_q    <= !sel_legal;
      end
      if (state_q == S_RESP) err_q <= 1'b0;
    end
  end

  // Ready is the only combinational output; held low while reset is applied.
  assign req_ready_o     = (state_q == S_IDLE && !rst_i) ? gnt_oh : '0;
  assign rsp_valid_o     = (state_q == S_RESP) ? gnt_oh_q : '0;
  assign rsp_error_o     = (state_q == S_RESP) && err_q;
  assign cmo_req_valid_o = (state_q == S_ISSUE);
  assign cmo_req_op_o    = op_q;
  assign cmo_req_addr_o  = addr_q;
  assign cmo_req_wdata_o = wdata_q;
  assign busy_o          = (state_q != S_IDLE);

`ifdef HPDCACHE_CMO_ARB_STATS_EN
  logic [STATS_W-1:0] fence_cnt_q, inval_cnt_q, err_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fence_cnt_q <= '0;
      inval_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else if (state_q == S_RESP) begin
      if (err_q) begin
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + STATS_W'(1);
      end else if (op_q[0]) begin
        if (fence_cnt_q != '1) fence_cnt_q <= fence_cnt_q + STATS_W'(1);
      end else begin
        if (inval_cnt_q != '1) inval_cnt_q <= inval_cnt_q + STATS_W'(1);
      end
    end
  end

  assign stat_fence_o = fence_cnt_q;
  assign stat_inval_o = inval_cnt_q;
  assign stat_err_o   = err_cnt_q;
`endif

endmodule

// File: tb/tb_hpdcache_cmo_arb.sv
// Self-checking bench for hpdcache_cmo_arb: directed scenarios plus randomized traffic
// against a transaction-timing reference model.
`timescale 1ns/1ps
module tb_hpdcache_cmo_arb;
  localparam int N  = 3;
  localparam int AW = 40;
  localparam int DW = 64;
  localparam int SW = 2;
  localparam int SMAX = 3;

  typedef logic [N-1:0]    vld_t;
  typedef logic [N*4-1:0]  opv_t;
  typedef logic [N*AW-1:0] adv_t;
  typedef logic [N*DW-1:0] wdv_t;

  logic          clk = 1'b0;
  logic          rst;
  vld_t          req_valid, req_ready, rsp_valid;
  opv_t          req_op;
  adv_t          req_addr;
  wdv_t          req_wdata;
  logic          rsp_error, cmo_valid, cmo_ready, busy;
  logic [3:0]    cmo_op;
  logic [AW-1:0] cmo_addr;
  logic [DW-1:0] cmo_wdata;
`ifdef HPDCACHE_CMO_ARB_STATS_EN
  logic [SW-1:0] st_fence, st_inval, st_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  hpdcache_cmo_arb #(.N_REQ(N), .STATS_W(SW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_op_i        (req_op),
    .req_addr_i      (req_addr),
    .req_wdata_i     (req_wdata),
    .rsp_valid_o     (rsp_valid),
    .rsp_error_o     (rsp_error),
    .cmo_req_valid_o (cmo_valid),
    .cmo_req_ready_i (cmo_ready),
    .cmo_req_op_o    (cmo_op),
    .cmo_req_addr_o  (cmo_addr),
    .cmo_req_wdata_o (cmo_wdata),
`ifdef HPDCACHE_CMO_ARB_STATS_EN
    .stat_fence_o    (st_fence),
    .stat_inval_o    (st_inval),
    .stat_err_o      (st_err),
`endif
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one outstanding transaction described by the cycles of its events.
  int            cyc = 0;
  bit            m_act;
  int            m_g, m_rr, m_hs, m_resp;
  logic [3:0]    m_op;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;
  bit            m_legal;
  int            s_fence, s_inval, s_err;

  always @(negedge clk) begin
    vld_t e_ready, e_rsp;
    logic e_err, e_cv, e_busy;
    bit   found;
    cyc++;
    if (rst) begin
      m_act = 0; m_rr = 0; s_fence = 0; s_inval = 0; s_err = 0;
    end else begin
      e_ready = '0; e_rsp = '0; e_err = 1'b0; e_cv = 1'b0; e_busy = m_act;
      if (!m_act) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && ((req_valid >> ((m_rr + k) % N)) & vld_t'(1)) != '0) begin
            found = 1;
            m_g   = (m_rr + k) % N;
          end
        end
        if (found) begin
          e_ready = vld_t'(1) << m_g;
          m_act   = 1;
          m_op    = 4'(req_op >> (m_g * 4));
          m_addr  = AW'(req_addr >> (m_g * AW));
          m_wd    = DW'(req_wdata >> (m_g * DW));
          m_legal = ($countones(m_op) == 1);
          m_hs    = -1;
          m_resp  = m_legal ? -1 : cyc + 1;
          m_rr    = (m_g + 1) % N;
        end
      end else begin
        if (m_legal && m_hs < 0) begin
          e_cv = 1'b1;
          if (cmo_ready) m_hs = cyc;
        end else if (m_legal && m_resp < 0) begin
          if (cmo_ready) m_resp = cyc + 1;
        end
        if (cyc == m_resp) begin
          e_rsp = vld_t'(1) << m_g;
          e_err = !m_legal;
        end
      end
      chk("mdl_req_ready", 64'(req_ready), 64'(e_ready));
      chk("mdl_rsp_valid", 64'(rsp_valid), 64'(e_rsp));
      chk("mdl_rsp_error", 64'(rsp_error), 64'(e_err));
      chk("mdl_cmo_valid", 64'(cmo_valid), 64'(e_cv));
      chk("mdl_busy",      64'(busy),      64'(e_busy));
      if (e_cv) begin
        chk("mdl_cmo_op",    64'(cmo_op),    64'(m_op));
        chk("mdl_cmo_addr",  64'(cmo_addr),  64'(m_addr));
        chk("mdl_cmo_wdata", 64'(cmo_wdata), 64'(m_wd));
      end
`ifdef HPDCACHE_CMO_ARB_STATS_EN
      chk("mdl_stat_fence", 64'(st_fence), 64'(s_fence));
      chk("mdl_stat_inval", 64'(st_inval), 64'(s_inval));
      chk("mdl_stat_err",   64'(st_err),   64'(s_err));
`endif
      if (e_rsp != '0) begin
        if (e_err)        s_err   = (s_err   < SMAX) ? s_err + 1   : SMAX;
        else if (m_op[0]) s_fence = (s_fence < SMAX) ? s_fence + 1 : SMAX;
        else              s_inval = (s_inval < SMAX) ? s_inval + 1 : SMAX;
        m_act = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_fields(input int r, input logic [3:0] op, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
    req_op    = (req_op    & ~(opv_t'(4'hF) << (r * 4)))   | (opv_t'(op) << (r * 4));
    req_addr  = (req_addr  & ~(adv_t'({AW{1'b1}}) << (r * AW))) | (adv_t'(a) << (r * AW));
    req_wdata = (req_wdata & ~(wdv_t'({DW{1'b1}}) << (r * DW))) | (wdv_t'(d) << (r * DW));
  endtask

  task automatic set_req(input int r, input logic [3:0] op, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    put_fields(r, op, a, d);
    req_valid = req_valid | (vld_t'(1) << r);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk({name, "_idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int gq[$];
    int gcyc[$];
    int budget;
    int rsp_cnt;
    logic [3:0] op;

    rst = 1'b1; req_valid = '0; req_op = '0; req_addr = '0; req_wdata = '0; cmo_ready = 1'b1;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_error", 64'(rsp_error), 64'(0));
    chk("rst_cmo_valid", 64'(cmo_valid), 64'(0));
    chk("rst_busy",      64'(busy),      64'(0));
    chk("rst_cmo_op",    64'(cmo_op),    64'(0));
    chk("rst_cmo_addr",  64'(cmo_addr),  64'(0));
    chk("rst_cmo_wdata", 64'(cmo_wdata), 64'(0));

    // Fast fence from requester 1
    tick();
    set_req(1, 4'b0001, 40'h12_3456_7840, 64'h0000_0000_0000_00FF);
    @(negedge clk); chk("t1_ready", 64'(req_ready), 64'(3'b010));
    tick(); req_valid = '0;
    @(negedge clk); chk("t1_handshake", 64'(cmo_valid), 64'(1));
    tick();
    @(negedge clk); chk("t1_no_rsp_t2", 64'(rsp_valid), 64'(0));
    tick();
    @(negedge clk);
    chk("t1_rsp", 64'(rsp_valid), 64'(3'b010));
    chk("t1_err", 64'(rsp_error), 64'(0));
    tick();

    // Round robin with all requesters valid
    do_reset();
    for (int r = 0; r < N; r++) set_req(r, 4'b0100, AW'(r * 64), DW'(r));
    budget = 0;
    while (gq.size() < 6 && budget < 60) begin
      @(negedge clk);
      for (int r = 0; r < N; r++)
        if (((req_ready >> r) & vld_t'(1)) != '0) begin
          gq.push_back(r);
          gcyc.push_back(budget);
        end
      tick();
      budget++;
    end
    req_valid = '0;
    chk("t2_grant_count", 64'(gq.size()), 64'(6));
    for (int i = 0; i < gq.size(); i++) chk($sformatf("t2_grant%0d", i), 64'(gq[i]), 64'(i % 3));
    for (int i = 1; i < gcyc.size(); i++)
      chk($sformatf("t2_gap%0d", i), 64'(gcyc[i] - gcyc[i-1]), 64'(4));
    wait_idle("t2");

    // Handler busy on issue and on completion
    cmo_ready = 1'b0;
    set_req(0, 4'b0001, 40'hAB_CDEF_0120, 64'h5A5A);
    @(negedge clk); chk("t3_ready", 64'(req_ready), 64'(3'b001));
    for (int k = 0; k < 5; k++) begin
      tick(); req_valid = '0;
      @(negedge clk);
      chk($sformatf("t3_cv%0d", k), 64'(cmo_valid), 64'(1));
      chk($sformatf("t3_addr%0d", k), 64'(cmo_addr), 64'(40'hAB_CDEF_0120));
      chk($sformatf("t3_op%0d", k), 64'(cmo_op), 64'(4'b0001));
    end
    tick(); cmo_ready = 1'b1;
    @(negedge clk); chk("t3_handshake", 64'(cmo_valid), 64'(1));
    rsp_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick(); cmo_ready = 1'b0;
      @(negedge clk);
      chk($sformatf("t3_wait_busy%0d", k), 64'(busy), 64'(1));
      if (rsp_valid != '0) rsp_cnt++;
    end
    tick(); cmo_ready = 1'b1;
    @(negedge clk); if (rsp_valid != '0) rsp_cnt++;
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk); if (rsp_valid != '0) rsp_cnt++;
    end
    chk("t3_rsp_count", 64'(rsp_cnt), 64'(1));
    tick();
    wait_idle("t3");

    // Illegal op from requester 2
    do_reset();
    set_req(2, 4'b0011, 40'h100, 64'h1);
    @(negedge clk);
    chk("t4_ready", 64'(req_ready), 64'(3'b100));
    chk("t4_cv0", 64'(cmo_valid), 64'(0));
    tick(); req_valid = '0;
    @(negedge clk);
    chk("t4_rsp", 64'(rsp_valid), 64'(3'b100));
    chk("t4_err", 64'(rsp_error), 64'(1));
    chk("t4_cv1", 64'(cmo_valid), 64'(0));
    tick();
    @(negedge clk);
    chk("t4_idle", 64'(busy), 64'(0));
`ifdef HPDCACHE_CMO_ARB_STATS_EN
    chk("t4_stat_err", 64'(st_err), 64'(1));
`endif

    // Reset while in WAIT
    tick();
    set_req(1, 4'b0001, 40'h200, 64'h2);
    @(negedge clk); chk("t5_ready", 64'(req_ready), 64'(3'b010));
    tick(); req_valid = '0;
    tick(); cmo_ready = 1'b0;
    @(negedge clk); chk("t5_in_wait", 64'(busy), 64'(1));
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("t5_ready0", 64'(req_ready), 64'(0));
    chk("t5_rsp0",   64'(rsp_valid), 64'(0));
    chk("t5_err0",   64'(rsp_error), 64'(0));
    chk("t5_cv0",    64'(cmo_valid), 64'(0));
    chk("t5_busy0",  64'(busy),      64'(0));
    tick();
    set_req(0, 4'b0001, 40'h300, 64'h3);
    set_req(1, 4'b0001, 40'h340, 64'h4);
    @(negedge clk); chk("t5_regrant", 64'(req_ready), 64'(3'b001));
    tick(); req_valid = '0; cmo_ready = 1'b1;
    wait_idle("t5");

    // Stats saturation: five fences
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_req(0, 4'b0001, AW'(i * 64), DW'(i));
      tick(); req_valid = '0;
      wait_idle($sformatf("t6_%0d", i));
    end
`ifdef HPDCACHE_CMO_ARB_STATS_EN
    @(negedge clk);
    chk("t6_stat_fence", 64'(st_fence), 64'(3));
    chk("t6_stat_inval", 64'(st_inval), 64'(0));
`endif

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req_valid = vld_t'($urandom_range(0, 7));
      for (int r = 0; r < N; r++) begin
        op = ($urandom_range(0, 9) == 0) ? 4'($urandom()) : (4'b0001 << $urandom_range(0, 3));
        put_fields(r, op, AW'({$urandom(), $urandom()}), {$urandom(), $urandom()});
      end
      cmo_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; req_valid = '0; cmo_ready = 1'b1;
    tick();
    wait_idle("rand_end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hpdcache_cmo_arb.md
# hpdcache_cmo_arb

Round-robin arbiter and sequencer between several cache-management-operation requesters (core CMO port, CSR flush engine, debug module) and the single HPDcache CMO handler. It grants one requester at a time and latches its operation, address and write data. It then issues the operation to the CMO handler with a valid/ready handshake, detects completion when the handler returns to idle, and returns a one-cycle response pulse to the granted requester. Only one CMO is ever in flight.

## Interface
Parameters:
- `N_REQ`, default 3: number of requesters, at least 2.
- `STATS_W`, default 16: width of the statistics counters (used only when `HPDCACHE_CMO_ARB_STATS_EN` is defined).

Ports:
- `clk_i` input 1: clock. One clock domain.
- `rst_i` input 1: reset, synchronous, active-high.
- `req_valid_i` input N_REQ: per-requester request valid.
- `req_ready_o` output N_REQ: per-requester accept. At most one bit is high in any cycle.
- `req_op_i` input N_REQ x hpdcache_cmoh_op_t: per-requester operation. Legal only if one-hot.
- `req_addr_i` input N_REQ x hpdcache_req_addr_t: per-requester address.
- `req_wdata_i` input N_REQ x hpdcache_req_data_t: per-requester write data (way mask in word 0).
- `rsp_valid_o` output N_REQ: per-requester completion pulse, registered.
- `rsp_error_o` output 1: qualifies `rsp_valid_o`; high means the operation was illegal and was not issued.
- `cmo_req_valid_o` output 1: request to the CMO handler.
- `cmo_req_ready_i` input 1: CMO handler ready. High only while the handler is idle.
- `cmo_req_op_o`, `cmo_req_addr_o`, `cmo_req_wdata_o` output: latched request fields, held stable while in ISSUE.
- `busy_o` output 1: high when the state is not IDLE.
- `stat_fence_o`, `stat_inval_o`, `stat_err_o` output STATS_W each: present only with the macro.

## Operation
States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req_valid_i` is high, grant the first valid requester at or after `rr_ptr_q` (wrapping modulo N_REQ).
  - Assert `req_ready_o[g]` combinationally in the same cycle.
  - Latch op, addr, wdata and `g`.
  - Set `rr_ptr_q` to (g+1) mod N_REQ.
  - If the op is one-hot, go to ISSUE. Otherwise set `err_q` and go to RESP.
- **ISSUE**
  - Assert `cmo_req_valid_o`.
  - On `cmo_req_ready_i` (handshake), go to WAIT. Otherwise stay; valid stays asserted with stable fields.
- **WAIT**
  - When `cmo_req_ready_i` is 1, the handler is back in idle and the operation is complete; go to RESP.
  - A fence with empty write buffer and RTAB completes in the first WAIT cycle.
- **RESP**
  - `rsp_valid_o[g]` = 1 and `rsp_error_o` = `err_q` for exactly one cycle.
  - Clear `err_q` and go to IDLE.
  - No new grant is made in RESP.

Further rules:
- Only the granted requester's pointer advances the round robin. Requester inputs are ignored outside IDLE.
- `req_ready_o` is never asserted outside IDLE.
- On reset:
  - State goes to IDLE and `rr_ptr_q` to 0.
  - `req_ready_o`, `rsp_valid_o`, `rsp_error_o`, `cmo_req_valid_o` and `busy_o` are 0.
  - Latched fields are 0.
  - A handler that is still busy is tolerated: the next ISSUE simply waits for `cmo_req_ready_i`.

## Timing
- Request accepted at cycle T.
- `cmo_req_valid_o` is asserted at T+1.
- With the handler ready, the handshake happens at T+1 and WAIT starts at T+2.
- If the handler is idle at T+2 (fast fence), `rsp_valid_o` pulses at T+3. Minimum accept-to-response latency is 3 cycles.
- The next grant happens no earlier than T+4, so sustained throughput is at most 1 op per 4 cycles.
- Illegal op: accepted at T, `rsp_valid_o` with `rsp_error_o` = 1 at T+1, next grant at T+2.
- All outputs except `req_ready_o` are driven directly from registers or from state decode.

## Configuration
Macro: `HPDCACHE_CMO_ARB_STATS_EN`.
- **Defined:** three saturating counters.
  - `stat_fence_o` increments at RESP of a successful fence.
  - `stat_inval_o` increments at RESP of any successful inval.
  - `stat_err_o` increments at RESP with error.
  - Each counter stops at 2^STATS_W−1.
  - Reset clears all three.
- **Not defined:** counters and stat ports are absent. Arbitration and sequencing behaviour is identical.

## Test plan
1. **Fast fence.** Reset, then requester 1 sends op = is_fence with handler ready constantly.
   - `req_ready_o` = 3'b010 at T.
   - Handshake at T+1.
   - `rsp_valid_o` = 3'b010 at T+3 with `rsp_error_o` = 0.
2. **Round robin.** All three requesters assert valid continuously with inval_all ops.
   - Grants go 0, 1, 2, 0, 1, 2.
   - No requester is starved.
   - Each grant follows the previous RESP by 1 cycle.
3. **Handler busy.** `cmo_req_ready_i` is held 0 for 5 cycles after ISSUE is entered.
   - `cmo_req_valid_o` stays 1 with stable addr/op.
   - Handshake occurs on the 6th cycle.
   - In WAIT, ready is held 0 for 20 cycles; then `rsp_valid_o` pulses exactly once.
4. **Illegal op.** Requester 2 sends op = 4'b0011.
   - Accepted.
   - `cmo_req_valid_o` is never asserted.
   - `rsp_valid_o` = 3'b100 with `rsp_error_o` = 1 at T+1.
   - `stat_err_o` = 1 with the macro defined.
5. **Reset mid-WAIT.** `rst_i` is asserted for 1 cycle while in WAIT.
   - Next cycle: all outputs 0, `busy_o` = 0, no `rsp_valid_o` pulse.
   - A new request from requester 0 is granted first (`rr_ptr_q` = 0).
6. **Stats saturation.** With `STATS_W` = 2, complete 5 fences.
   - `stat_fence_o` = 3.
   - `stat_inval_o` = 0.
